key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of two, >=2).
REQ-002 The block SHALL have port pixel_clk_in, input, 1, sole clock.
REQ-003 The block SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port byte_valid_in, input, 1, one-cycle strobe marking a received PS/2 set-2 scan byte.
REQ-005 The block SHALL have port byte_in, input, 8, scan byte, sampled only when byte_valid_in=1.
REQ-006 The block SHALL have port ready_in, input, 1, terminal_controller side accepts the head event.
REQ-007 The block SHALL have port event_valid_out, output, 1, head event present.
REQ-008 The block SHALL have port event_type_out, output, 2, 0=CHAR, 1=ENTER, 2=BKSP, 3 unused.
REQ-009 The block SHALL have port char_out, output, 8, ASCII for CHAR events, 0x00 otherwise.
REQ-010 The block SHALL have port shift_out, output, 1, current shift-held state.
REQ-011 The block SHALL have port overflow_out, output, 1, sticky flag set when an event is dropped.

Function
REQ-012 Prefix FSM SHALL have states IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (0xE0 then 0xF0); transitions occur only on byte_valid_in.
REQ-013 IDLE: 0xF0->BRK, 0xE0->EXT, other byte = make code, decode, stay IDLE.
REQ-014 BRK: any byte = break code, no event, ->IDLE; 0x12 or 0x59 clears the respective shift bit.
REQ-015 EXT: 0xF0->EXT_BRK; other byte dropped, ->IDLE. EXT_BRK: any byte dropped, ->IDLE.
REQ-016 Make 0x12 sets lshift, 0x59 sets rshift, no event; shift_out = lshift OR rshift.
REQ-017 Make 0x5A SHALL produce ENTER; 0x66 SHALL produce BKSP; 0x29 SHALL produce CHAR 0x20.
REQ-018 Letters (set 2: a1C b32 c21 d23 e24 f2B g34 h33 i43 j3B k42 l4B m3A n31 o44 p4D q15 r2D s1B t2C u3C v2A w1D x22 y35 z1A) SHALL produce CHAR lowercase ASCII, uppercase when shift_out=1 at decode.
REQ-019 Digits (0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46) SHALL produce ASCII '0'-'9' regardless of shift.
REQ-020 All other make codes SHALL be dropped silently, FSM unaffected beyond REQ-013.
REQ-021 Repeated make codes (typematic) without break SHALL each produce an event.
REQ-022 A decoded event SHALL be written to the FIFO on the clock edge after byte_valid_in; event_valid_out SHALL rise the following cycle when the FIFO was empty (2-cycle byte-to-valid latency).
REQ-023 Outputs SHALL present FIFO head (registered, first-word fall-through); head pops on edge where event_valid_out AND ready_in.
REQ-024 event_type_out/char_out SHALL hold stable while event_valid_out=1 and ready_in=0.
REQ-025 Push when full and no pop: event dropped, overflow_out set to 1 and held until reset.
REQ-026 Push and pop in same cycle when full: both occur, no drop, occupancy unchanged.
REQ-027 Push and pop same cycle when one entry: new event becomes head next cycle, event_valid_out stays 1.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-029 byte_valid_in SHALL never be back-pressured; every byte advances the FSM.

Reset
REQ-030 While rst_in=1, asynchronously: FSM=IDLE, lshift=rshift=0, FIFO empty, event_valid_out=0, event_type_out=0, char_out=0x00, shift_out=0, overflow_out=0.
REQ-031 Reset mid-sequence (e.g. after 0xF0) SHALL discard prefix state; next byte decodes from IDLE.

Verification
REQ-032 Bytes 0x1C, then 0xF0,0x1C, ready_in=1 -> exactly one event CHAR 'a' (0x61), valid 2 cycles after first strobe, none from break.
REQ-033 Bytes 0x12,0x1C,0xF0,0x12,0x1C -> events 'A'(0x41) then 'a'(0x61); shift_out 1 then 0.
REQ-034 ready_in=0, bytes 0x5A,0x66,0x16,0x1E,0x26 (depth 4) -> FIFO holds ENTER,BKSP,'1','2'; '3' dropped; overflow_out=1; releasing ready_in drains in order.
REQ-035 Bytes 0xE0,0x75 then 0xE0,0xF0,0x75 then 0x29 -> only CHAR 0x20 emitted; FSM back in IDLE.
REQ-036 Full FIFO with ready_in=1 and byte_valid_in same cycle -> no drop, overflow_out stays 0, order preserved.
REQ-037 Assert rst_in after 0xF0 and between clock edges with 2 queued events -> outputs zero immediately; next byte 0x1C yields 'a'.

Source files
------------

// File: rtl/key_event_decoder_if.sv
// Keyboard byte input and decoded-event output bundle for key_event_decoder.
// slave: the decoder side. master: the byte source and event consumer side.
interface key_event_decoder_if;
  logic       byte_valid_in;
  logic [7:0] byte_in;
  logic       ready_in;
  logic       event_valid_out;
  logic [1:0] event_type_out;
  logic [7:0] char_out;
  logic       shift_out;
  logic       overflow_out;

  modport slave (
    input  byte_valid_in, byte_in, ready_in,
    output event_valid_out, event_type_out, char_out, shift_out, overflow_out
  );

  modport master (
    output byte_valid_in, byte_in, ready_in,
    input  event_valid_out, event_type_out, char_out, shift_out, overflow_out
  );
endinterface

// File: rtl/key_event_decoder.sv
// PS/2 set-2 scan byte decoder.
// Bytes pass through a prefix FSM (break/extended handling) and a shift
// tracker. Decoded key events are registered once, then pushed into a
// first-word-fall-through FIFO. The result is 2 cycles from byte strobe to
// event_valid_out when the FIFO is empty. Dropped events set a sticky
// overflow flag.
module key_event_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  key_event_decoder_if.slave kbd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] EV_CHAR  = 2'd0;
  localparam logic [1:0] EV_ENTER = 2'd1;
  localparam logic [1:0] EV_BKSP  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  // Printable lookup: {is_letter, hit, lowercase/digit ASCII}
  function automatic logic [9:0] f_lut(input logic [7:0] b);
    logic [9:0] r;
    case (b)
      8'h1C: r = {2'b11, 8'h61}; 8'h32: r = {2'b11, 8'h62};
      8'h21: r = {2'b11, 8'h63}; 8'h23: r = {2'b11, 8'h64};
      8'h24: r = {2'b11, 8'h65}; 8'h2B: r = {2'b11, 8'h66};
      8'h34: r = {2'b11, 8'h67}; 8'h33: r = {2'b11, 8'h68};
      8'h43: r = {2'b11, 8'h69}; 8'h3B: r = {2'b11, 8'h6A};
      8'h42: r = {2'b11, 8'h6B}; 8'h4B: r = {2'b11, 8'h6C};
      8'h3A: r = {2'b11, 8'h6D}; 8'h31: r = {2'b11, 8'h6E};
      8'h44: r = {2'b11, 8'h6F}; 8'h4D: r = {2'b11, 8'h70};
      8'h15: r = {2'b11, 8'h71}; 8'h2D: r = {2'b11, 8'h72};
      8'h1B: r = {2'b11, 8'h73}; 8'h2C: r = {2'b11, 8'h74};
      8'h3C: r = {2'b11, 8'h75}; 8'h2A: r = {2'b11, 8'h76};
      8'h1D: r = {2'b11, 8'h77}; 8'h22: r = {2'b11, 8'h78};
      8'h35: r = {2'b11, 8'h79}; 8'h1A: r = {2'b11, 8'h7A};
      8'h45: r = {2'b01, 8'h30}; 8'h16: r = {2'b01, 8'h31};
      8'h1E: r = {2'b01, 8'h32}; 8'h26: r = {2'b01, 8'h33};
      8'h25: r = {2'b01, 8'h34}; 8'h2E: r = {2'b01, 8'h35};
      8'h36: r = {2'b01, 8'h36}; 8'h3D: r = {2'b01, 8'h37};
      8'h3E: r = {2'b01, 8'h38}; 8'h46: r = {2'b01, 8'h39};
      default: r = 10'd0;
    endcase
    return r;
  endfunction

  state_t     r_state, w_state_nxt;
  logic       r_lshift, r_rshift, w_lshift_nxt, w_rshift_nxt;
  logic       w_shift;
  logic [9:0] w_lut;
  logic       w_dec_vld;
  logic [1:0] w_dec_type;
  logic [7:0] w_dec_char;
  logic       r_dec_vld;
  logic [1:0] r_dec_type;
  logic [7:0] r_dec_char;

  logic [FIFO_DEPTH-1:0][1:0] r_mem_type;
  logic [FIFO_DEPTH-1:0][7:0] r_mem_char;
  logic [AW-1:0]              r_wr, r_rd;
  logic [CW-1:0]              r_count;
  logic                       r_ovf;
  logic                       w_valid, w_full, w_pop, w_push;

  assign w_shift = r_lshift | r_rshift;
  assign w_lut   = f_lut(kbd.byte_in);

  // Prefix FSM and shift state registers
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lshift <= w_lshift_nxt;
      r_rshift <= w_rshift_nxt;
    end
  end

  // Next prefix state, shift updates and make-code decode; shift used is pre-byte
  always_comb begin
    w_state_nxt  = r_state;
    w_lshift_nxt = r_lshift;
    w_rshift_nxt = r_rshift;
    w_dec_vld    = 1'b0;
    w_dec_type   = EV_CHAR;
    w_dec_char   = 8'h00;
    if (kbd.byte_valid_in) begin
      case (r_state)
        S_IDLE: begin
          if (kbd.byte_in == 8'hF0)      w_state_nxt = S_BRK;
          else if (kbd.byte_in == 8'hE0) w_state_nxt = S_EXT;
          else begin
            case (kbd.byte_in)
              8'h12: w_lshift_nxt = 1'b1;
              8'h59: w_rshift_nxt = 1'b1;
              8'h5A: begin w_dec_vld = 1'b1; w_dec_type = EV_ENTER; end
              8'h66: begin w_dec_vld = 1'b1; w_dec_type = EV_BKSP;  end
              8'h29: begin w_dec_vld = 1'b1; w_dec_char = 8'h20;    end
              default: begin
                if (w_lut[8]) begin
                  w_dec_vld  = 1'b1;
                  w_dec_char = (w_lut[9] && w_shift) ? (w_lut[7:0] - 8'h20) : w_lut[7:0];
                end
              end
            endcase
          end
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          if (kbd.byte_in == 8'h12) w_lshift_nxt = 1'b0;
          if (kbd.byte_in == 8'h59) w_rshift_nxt = 1'b0;
        end
        S_EXT:     w_state_nxt = (kbd.byte_in == 8'hF0) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Decoded-event stage; gives the one extra cycle before the FIFO write
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_dec_vld  <= 1'b0;
      r_dec_type <= EV_CHAR;
      r_dec_char <= 8'h00;
    end else begin
      r_dec_vld  <= w_dec_vld;
      r_dec_type <= w_dec_type;
      r_dec_char <= w_dec_char;
    end
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = w_valid & kbd.ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push  = r_dec_vld & (~w_full | w_pop);

  // FIFO storage; contents need no reset since outputs are gated by valid
  always_ff @(posedge pixel_clk_in) begin
    if (w_push) begin
      r_mem_type[r_wr] <= r_dec_type;
      r_mem_char[r_wr] <= r_dec_char;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (r_dec_vld && !w_push) r_ovf <= 1'b1;
    end
  end

  assign kbd.event_valid_out = w_valid;
  assign kbd.event_type_out  = w_valid ? r_mem_type[r_rd] : 2'd0;
  assign kbd.char_out        = w_valid ? r_mem_char[r_rd] : 8'h00;
  assign kbd.shift_out       = w_shift;
  assign kbd.overflow_out    = r_ovf;
endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios with literal expectations,
// then random bytes, all compared every cycle against a queue-based model.
module tb_key_event_decoder;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0] t;
    logic [7:0] c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  key_event_decoder_if bus();

  key_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .kbd         (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                          8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                          8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // ---------------- reference model ----------------
  ev_t q[$];
  ev_t pend;
  bit  pend_v, m_lsh, m_rsh, m_f0, m_e0, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic emit(input logic [1:0] t, input logic [7:0] c);
    pend.t = t;
    pend.c = c;
    pend_v = 1'b1;
  endtask

  task automatic model_make(input logic [7:0] b);
    if (b == 8'h12) m_lsh = 1'b1;
    else if (b == 8'h59) m_rsh = 1'b1;
    else if (b == 8'h5A) emit(2'd1, 8'h00);
    else if (b == 8'h66) emit(2'd2, 8'h00);
    else if (b == 8'h29) emit(2'd0, 8'h20);
    else begin
      for (int i = 0; i < 26; i++)
        if (lc[i] == b) emit(2'd0, 8'((m_lsh || m_rsh) ? 65 + i : 97 + i));
      for (int i = 0; i < 10; i++)
        if (dc[i] == b) emit(2'd0, 8'(48 + i));
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_e0 && !m_f0) begin
      if (b == 8'hF0) m_f0 = 1'b1;
      else if (b == 8'hE0) m_e0 = 1'b1;
      else model_make(b);
    end else if (m_f0 && !m_e0) begin
      if (b == 8'h12) m_lsh = 1'b0;
      if (b == 8'h59) m_rsh = 1'b0;
      m_f0 = 1'b0;
    end else if (m_e0 && !m_f0) begin
      if (b == 8'hF0) m_f0 = 1'b1;
      else m_e0 = 1'b0;
    end else begin
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end
  endtask

  // Model: pop, then last cycle's decoded event enters the queue, then decode this byte
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      pend_v = 1'b0; m_lsh = 1'b0; m_rsh = 1'b0; m_f0 = 1'b0; m_e0 = 1'b0; m_ovf = 1'b0;
    end else begin
      if (q.size() > 0 && bus.ready_in) void'(q.pop_front());
      if (pend_v) begin
        if (q.size() < DEPTH) q.push_back(pend);
        else m_ovf = 1'b1;
      end
      pend_v = 1'b0;
      if (bus.byte_valid_in) model_byte(bus.byte_in);
    end
  end

  // Compare DUT against the model every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 32'(bus.event_valid_out), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("type", 32'(bus.event_type_out), 32'(q[0].t));
        chk("char", 32'(bus.char_out), 32'(q[0].c));
      end else begin
        chk("type_idle", 32'(bus.event_type_out), 32'd0);
        chk("char_idle", 32'(bus.char_out), 32'd0);
      end
      chk("shift", 32'(bus.shift_out), 32'(m_lsh | m_rsh));
      chk("overflow", 32'(bus.overflow_out), 32'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.byte_valid_in = 1'b1;
    bus.byte_in       = b;
    @(posedge clk); #1;
    bus.byte_valid_in = 1'b0;
    bus.byte_in       = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic head(input string name, input logic [1:0] t, input logic [7:0] c);
    chk({name, "_v"}, 32'(bus.event_valid_out), 32'd1);
    chk({name, "_t"}, 32'(bus.event_type_out), 32'(t));
    chk({name, "_c"}, 32'(bus.char_out), 32'(c));
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    idle(1);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(7, 0))
      0: return 8'hF0;
      1: return 8'hE0;
      2: return ($urandom_range(1, 0) != 0) ? 8'h12 : 8'h59;
      3, 7: return lc[$urandom_range(25, 0)];
      4: return dc[$urandom_range(9, 0)];
      5: case ($urandom_range(2, 0))
           0: return 8'h5A;
           1: return 8'h66;
           default: return 8'h29;
         endcase
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    bus.byte_valid_in = 1'b0;
    bus.byte_in       = 8'h00;
    bus.ready_in      = 1'b0;
    #3;
    chk("rst_valid", 32'(bus.event_valid_out), 32'd0);
    chk("rst_type",  32'(bus.event_type_out), 32'd0);
    chk("rst_char",  32'(bus.char_out), 32'd0);
    chk("rst_shift", 32'(bus.shift_out), 32'd0);
    chk("rst_ovf",   32'(bus.overflow_out), 32'd0);
    #20 rst = 1'b0;
    idle(2);

    // single make then break: one 'a', 2-cycle latency
    bus.ready_in = 1'b1;
    send(8'h1C);
    chk("lat_1cyc", 32'(bus.event_valid_out), 32'd0);
    idle(1);
    head("a_make", 2'd0, 8'h61);
    send(8'hF0); send(8'h1C);
    idle(3);
    chk("no_break_ev", 32'(bus.event_valid_out), 32'd0);

    // shift held / released
    send(8'h12);
    chk("shift_on", 32'(bus.shift_out), 32'd1);
    send(8'h1C); idle(1);
    head("A_shift", 2'd0, 8'h41);
    send(8'hF0); send(8'h12);
    chk("shift_off", 32'(bus.shift_out), 32'd0);
    send(8'h1C); idle(1);
    head("a_noshift", 2'd0, 8'h61);
    idle(2);

    // overflow with consumer stalled, then ordered drain
    bus.ready_in = 1'b0;
    send(8'h5A); send(8'h66); send(8'h16); send(8'h1E); send(8'h26);
    idle(2);
    chk("ovf_set", 32'(bus.overflow_out), 32'd1);
    bus.ready_in = 1'b1;
    head("drain_enter", 2'd1, 8'h00); idle(1);
    head("drain_bksp",  2'd2, 8'h00); idle(1);
    head("drain_1",     2'd0, 8'h31); idle(1);
    head("drain_2",     2'd0, 8'h32); idle(1);
    chk("drain_empty", 32'(bus.event_valid_out), 32'd0);
    chk("ovf_sticky",  32'(bus.overflow_out), 32'd1);
    reset_mid();

    // extended codes are dropped; space still decodes
    bus.ready_in = 1'b1;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
    idle(1);
    head("space", 2'd0, 8'h20);
    send(8'h1C); idle(1);
    head("after_ext", 2'd0, 8'h61);
    idle(2);
    reset_mid();

    // push and pop together while full
    bus.ready_in = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    idle(2);
    send(8'h24);
    bus.ready_in = 1'b1;
    head("full_a", 2'd0, 8'h61); idle(1);
    head("full_b", 2'd0, 8'h62); idle(1);
    head("full_c", 2'd0, 8'h63); idle(1);
    head("full_d", 2'd0, 8'h64); idle(1);
    head("full_e", 2'd0, 8'h65); idle(1);
    chk("full_empty", 32'(bus.event_valid_out), 32'd0);
    chk("full_no_ovf", 32'(bus.overflow_out), 32'd0);

    // async reset mid-prefix with queued events
    bus.ready_in = 1'b0;
    send(8'h1C); send(8'h32); idle(2);
    send(8'hF0);
    head("pre_rst", 2'd0, 8'h61);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.event_valid_out), 32'd0);
    chk("arst_char",  32'(bus.char_out), 32'd0);
    chk("arst_type",  32'(bus.event_type_out), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    send(8'h1C); idle(1);
    head("post_rst", 2'd0, 8'h61);
    bus.ready_in = 1'b1;
    idle(2);

    // random traffic: mostly-ready consumer, then a slow one to hit overflow
    for (int ph = 0; ph < 2; ph++) begin
      repeat (1500) begin
        @(posedge clk); #1;
        bus.byte_valid_in = ($urandom_range(1, 0) != 0);
        bus.byte_in       = pick();
        bus.ready_in      = ($urandom_range(99, 0) < ((ph == 0) ? 60 : 15));
      end
      bus.byte_valid_in = 1'b0;
      bus.ready_in      = 1'b1;
      idle(8);
      if (ph == 0) reset_mid();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
